// File: rtl/rom_serializer_pkg.sv
// Shared constants and types for the ROM burst serializer.
//   ADDR_W    : ROM address width (8 words)
//   DATA_W    : ROM word width
//   BIT_CNT_W : width of the per-word bit counter (must hold DATA_W-1)
//   stateT    : burst controller state encoding
package rom_serializer_pkg;

  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned DATA_W    = 14;
  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHIFT = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } stateT;

endpackage

// File: rtl/rom_serializer_if.sv
// Bundle of the serializer's command, ROM and serial-stream signals.
//   start/startAddr/lastAddr : burst request (sampled only while idle)
//   addrRom/recRom           : combinational ROM port (ROM lives outside)
//   serOut/serValid/serReady : MSB-first serial stream with valid/ready
//   wordDone/busy/done       : status
// master = requester/ROM/sink side, slave = serializer side.
interface rom_serializer_if #(
  parameter int unsigned ADDR_W = rom_serializer_pkg::ADDR_W,
  parameter int unsigned DATA_W = rom_serializer_pkg::DATA_W
);

  logic              start;
  logic [ADDR_W-1:0] startAddr;
  logic [ADDR_W-1:0] lastAddr;
  logic [ADDR_W-1:0] addrRom;
  logic [DATA_W-1:0] recRom;
  logic              serOut;
  logic              serValid;
  logic              serReady;
  logic              wordDone;
  logic              busy;
  logic              done;

  modport master (
    output start, startAddr, lastAddr, recRom, serReady,
    input  addrRom, serOut, serValid, wordDone, busy, done
  );

  modport slave (
    input  start, startAddr, lastAddr, recRom, serReady,
    output addrRom, serOut, serValid, wordDone, busy, done
  );

endinterface

// File: rtl/rom_serializer_piso_shift.sv
// Parallel-in serial-out word register with its bit counter.
//   clk, rstN : clock, async active-low reset (register and counter clear)
//   load      : capture parIn and preset the counter to DATA_W-1
//   shiftEn   : shift left by one (zero fill) and decrement the counter
//   parIn     : word to load
//   msb       : current outgoing bit
//   last      : counter is at 0, i.e. msb is the final bit of the word
module piso_shift #(
  parameter int unsigned DATA_W    = rom_serializer_pkg::DATA_W,
  parameter int unsigned BIT_CNT_W = rom_serializer_pkg::BIT_CNT_W
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              load,
  input  logic              shiftEn,
  input  logic [DATA_W-1:0] parIn,
  output logic              msb,
  output logic              last
);

  logic [DATA_W-1:0]    shiftReg;
  logic [BIT_CNT_W-1:0] bitCnt;

  // Load has priority; the controller never asserts both together.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      shiftReg <= '0;
      bitCnt   <= '0;
    end else if (load) begin
      shiftReg <= parIn;
      bitCnt   <= BIT_CNT_W'(DATA_W - 1);
    end else if (shiftEn) begin
      shiftReg <= {shiftReg[DATA_W-2:0], 1'b0};
      bitCnt   <= bitCnt - BIT_CNT_W'(1);
    end
  end

  assign msb  = shiftReg[DATA_W-1];
  assign last = (bitCnt == '0);

endmodule

// File: rtl/rom_serializer.sv
// Reads a run of words from an external combinational ROM and streams each
// one MSB first over a valid/ready serial link.
//   clk  : single clock, rising edge
//   rstN : async active-low reset; aborts any burst without a done pulse
//   bus  : rom_serializer_if.slave (command, ROM port, serial stream, status)
// Addresses run from startAddr to lastAddr inclusive, wrapping 7 -> 0.
// Per word: 1 FETCH cycle, DATA_W SHIFT transfers, 1 NEXT cycle (wordDone).
module rom_serializer #(
  parameter int unsigned ADDR_W = rom_serializer_pkg::ADDR_W,
  parameter int unsigned DATA_W = rom_serializer_pkg::DATA_W
) (
  input  logic           clk,
  input  logic           rstN,
  rom_serializer_if.slave bus
);

  import rom_serializer_pkg::*;

  stateT             state;
  stateT             stateNext;
  logic [ADDR_W-1:0] addrReg;
  logic [ADDR_W-1:0] addrNext;
  logic [ADDR_W-1:0] endReg;
  logic [ADDR_W-1:0] endNext;

  logic load;
  logic shiftEn;
  logic msb;
  logic last;

  logic serValidQ;
  logic wordDoneQ;
  logic doneQ;
  logic busyQ;

  // Word register and bit counter.
  piso_shift #(
    .DATA_W    (DATA_W),
    .BIT_CNT_W (BIT_CNT_W)
  ) uPiso (
    .clk     (clk),
    .rstN    (rstN),
    .load    (load),
    .shiftEn (shiftEn),
    .parIn   (bus.recRom),
    .msb     (msb),
    .last    (last)
  );

  // State, address and end-address registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      addrReg <= '0;
      endReg  <= '0;
    end else begin
      state   <= stateNext;
      addrReg <= addrNext;
      endReg  <= endNext;
    end
  end

  // Next-state, address update and datapath controls.
  always_comb begin
    stateNext = state;
    addrNext  = addrReg;
    endNext   = endReg;
    load      = 1'b0;
    shiftEn   = 1'b0;
    unique case (state)
      IDLE: begin
        // Addresses are captured only here, so start while busy is ignored.
        if (bus.start) begin
          addrNext  = bus.startAddr;
          endNext   = bus.lastAddr;
          stateNext = FETCH;
        end
      end
      FETCH: begin
        load      = 1'b1;
        stateNext = SHIFT;
      end
      SHIFT: begin
        if (serValidQ && bus.serReady) begin
          shiftEn = 1'b1;
          if (last) begin
            stateNext = NEXT;
          end
        end
      end
      NEXT: begin
        if (addrReg == endReg) begin
          stateNext = DONE;
        end else begin
          addrNext  = addrReg + ADDR_W'(1);
          stateNext = FETCH;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so each one is high
  // for exactly the cycles spent in its state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      serValidQ <= 1'b0;
      wordDoneQ <= 1'b0;
      doneQ     <= 1'b0;
      busyQ     <= 1'b0;
    end else begin
      serValidQ <= (stateNext == SHIFT);
      wordDoneQ <= (stateNext == NEXT);
      doneQ     <= (stateNext == DONE);
      busyQ     <= (stateNext != IDLE);
    end
  end

  assign bus.addrRom  = addrReg;
  assign bus.serValid = serValidQ;
  assign bus.serOut   = serValidQ & msb;
  assign bus.wordDone = wordDoneQ;
  assign bus.done     = doneQ;
  assign bus.busy     = busyQ;

endmodule

// File: tb/tb_rom_serializer.sv
// Scoreboard bench for rom_serializer: bursts push expected addresses and
// words into queues; a negedge monitor reassembles serial words and checks
// them, plus hold behaviour, idle-zero, pulse counts and reset outputs.
module tb_rom_serializer;

  logic clk = 1'b0;
  logic rstN;

  rom_serializer_if bus ();

  rom_serializer dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // External ROM model (hand-chosen contents).
  function automatic logic [13:0] romWord(input logic [2:0] a);
    case (a)
      3'd0:    return 14'h1555;
      3'd1:    return 14'h1999;
      3'd2:    return 14'h3C3C;
      3'd3:    return 14'h2AAA;
      3'd4:    return 14'h0001;
      3'd5:    return 14'h3FFF;
      3'd6:    return 14'h006C;
      default: return 14'h05AD;
    endcase
  endfunction

  assign bus.recRom = romWord(bus.addrRom);

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard state
  logic [13:0] wordQ[$];
  logic [2:0]  addrQ[$];
  int          bitCnt        = 0;
  int          wordsSeen     = 0;
  int          wordDoneCnt   = 0;
  int          doneCnt       = 0;
  int          firstValidCyc = -1;
  int          wordDoneCyc   = -1;
  int          doneCyc       = -1;
  int          cyc           = 0;
  logic [13:0] acc           = '0;
  bit          holdValid     = 1'b0;
  logic        holdBit       = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor
  always @(negedge clk) begin
    if (!rstN) begin
      check("resetOutputs", {24'd0, bus.addrRom, bus.serOut, bus.serValid,
                             bus.wordDone, bus.busy, bus.done}, 32'd0);
      bitCnt    = 0;
      holdValid = 1'b0;
    end else begin
      if (!bus.serValid) check("serOutIdleZero", 32'(bus.serOut), 32'd0);
      if (holdValid) begin
        check("holdValid", 32'(bus.serValid), 32'd1);
        check("holdBit", 32'(bus.serOut), 32'(holdBit));
      end
      holdValid = bus.serValid && !bus.serReady;
      holdBit   = bus.serOut;
      if (bus.serValid && bus.serReady) begin
        if (bitCnt == 0) begin
          if (firstValidCyc < 0) firstValidCyc = cyc;
          if (addrQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("FAIL addrSeq: unexpected word at addrRom=%0d, none expected", bus.addrRom);
          end else begin
            check("addrSeq", 32'(bus.addrRom), 32'(addrQ.pop_front()));
          end
        end
        acc = {acc[12:0], bus.serOut};
        bitCnt++;
        if (bitCnt == 14) begin
          if (wordQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("FAIL wordData: got 0x%0h, none expected", acc);
          end else begin
            check("wordData", 32'(acc), 32'(wordQ.pop_front()));
          end
          wordsSeen++;
          bitCnt = 0;
        end
      end
      if (bus.wordDone) begin
        wordDoneCnt++;
        wordDoneCyc = cyc;
        check("wordDoneAlign", 32'(bitCnt), 32'd0);
      end
      if (bus.done) begin
        doneCnt++;
        doneCyc = cyc;
      end
    end
  end

  task automatic pushBurst(input logic [2:0] sa, input logic [2:0] la, output int n);
    logic [2:0] diff;
    logic [2:0] a;
    diff = la - sa;
    n    = int'(diff) + 1;
    a    = sa;
    for (int i = 0; i < n; i++) begin
      addrQ.push_back(a);
      wordQ.push_back(romWord(a));
      a = a + 3'd1;
    end
  endtask

  task automatic issueStart(input logic [2:0] sa, input logic [2:0] la);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.startAddr = sa;
    bus.lastAddr  = la;
    bus.serReady  = 1'b1;
    cyc           = 1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.startAddr = ~sa;
    bus.lastAddr  = ~la;
    check("busyInFetch", 32'(bus.busy), 32'd1);
  endtask

  task automatic runBurst(input string tag, input logic [2:0] sa, input logic [2:0] la,
                          input bit toggleReady, input bit pokeStart);
    int n;
    int wd0;
    int d0;
    int w0;
    bit finished;
    pushBurst(sa, la, n);
    wd0           = wordDoneCnt;
    d0            = doneCnt;
    w0            = wordsSeen;
    firstValidCyc = -1;
    finished      = 1'b0;
    issueStart(sa, la);
    for (int k = 0; k < 2000; k++) begin
      if (doneCnt != d0) begin
        finished = 1'b1;
        break;
      end
      if (toggleReady) bus.serReady = ~bus.serReady;
      bus.start = pokeStart && (k == 20 || k == 40);
      if (bus.start) begin
        bus.startAddr = 3'd0;
        bus.lastAddr  = 3'd1;
      end
      @(posedge clk); #1;
    end
    bus.start    = 1'b0;
    bus.serReady = 1'b1;
    if (!finished) begin
      nChecks++;
      nFails++;
      $display("FAIL %s timeout: no done pulse within 2000 cycles", tag);
    end
    check({tag, ".wordDoneCount"}, 32'(wordDoneCnt - wd0), 32'(n));
    check({tag, ".wordsSeen"}, 32'(wordsSeen - w0), 32'(n));
    check({tag, ".doneCount"}, 32'(doneCnt - d0), 32'd1);
    check({tag, ".queuesEmpty"}, 32'(wordQ.size() + addrQ.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".singleDone"}, 32'(doneCnt - d0), 32'd1);
    check({tag, ".idleBusy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w0;
    int d0;
    bit hit;

    rstN          = 1'b0;
    bus.start     = 1'b0;
    bus.startAddr = '0;
    bus.lastAddr  = '0;
    bus.serReady  = 1'b0;
    #1;
    check("resetImmediate", {24'd0, bus.addrRom, bus.serOut, bus.serValid,
                             bus.wordDone, bus.busy, bus.done}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single word, exact latency: bits on 3..16, wordDone 17, done 18.
    runBurst("single0", 3'd0, 3'd0, 1'b0, 1'b0);
    check("firstBitCycle", 32'(firstValidCyc), 32'd3);
    check("wordDoneCycle", 32'(wordDoneCyc), 32'd17);
    check("doneCycle", 32'(doneCyc), 32'd18);

    runBurst("addr6to7", 3'd6, 3'd7, 1'b0, 1'b0);
    runBurst("wrap7to0", 3'd7, 3'd0, 1'b0, 1'b0);
    runBurst("backpressure", 3'd1, 3'd1, 1'b1, 1'b0);
    runBurst("allEight", 3'd2, 3'd1, 1'b0, 1'b0);
    runBurst("startIgnored", 3'd3, 3'd6, 1'b0, 1'b1);

    // Reset in the middle of the second word.
    pushBurst(3'd0, 3'd3, n);
    w0  = wordsSeen;
    d0  = doneCnt;
    hit = 1'b0;
    issueStart(3'd0, 3'd3);
    for (int k = 0; k < 200; k++) begin
      if (wordsSeen - w0 == 1 && bitCnt == 5) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!hit) begin
      nChecks++;
      nFails++;
      $display("FAIL midResetReach: bit 5 of word 2 not reached within 200 cycles");
    end
    rstN = 1'b0;
    #1;
    check("midResetOutputs", {24'd0, bus.addrRom, bus.serOut, bus.serValid,
                              bus.wordDone, bus.busy, bus.done}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    wordQ.delete();
    addrQ.delete();
    repeat (5) @(posedge clk);
    #1;
    check("midResetNoDone", 32'(doneCnt - d0), 32'd0);
    check("midResetIdle", 32'(bus.busy), 32'd0);
    runBurst("afterReset", 3'd5, 3'd5, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
